// File: rtl/if_id_stall_ctrl.sv
// PC register, IF/ID pipeline register and ID/EX valid bit driven by hazard-unit and branch controls.
// Optional: define STALL_COUNTER_EN to add a saturating stall_count output.
module if_id_stall_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [31:0]      imem_instr,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             id_ex_valid,
`ifdef STALL_COUNTER_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic             protocol_err
);

    // Redirect targets are word aligned; the low two bits are dropped.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    logic handshake_bad;
    assign handshake_bad = (PCWrite != ~stall) || (IF_ID_Write != ~stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            id_ex_valid  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (handshake_bad) begin
                protocol_err <= 1'b1;
            end
            if (branch_taken) begin
                pc          <= {branch_target[XLEN-1:2], 2'b00};
                if_id_pc    <= '0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
                id_ex_valid <= 1'b0;
            end else begin
                // PC and IF/ID enables are honoured independently of stall.
                if (PCWrite) begin
                    pc <= pc + XLEN'(4);
                end
                if (IF_ID_Write) begin
                    if_id_pc    <= pc;
                    if_id_instr <= imem_instr;
                    if_id_valid <= 1'b1;
                end
                id_ex_valid <= stall ? 1'b0 : if_id_valid;
            end
        end
    end

`ifdef STALL_COUNTER_EN
    // Saturating count of stall cycles; squashed (branch) cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !branch_taken && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed self-checking bench for if_id_stall_ctrl; stall_count checks are built only with STALL_COUNTER_EN.
module tb_if_id_stall_ctrl;

    localparam int CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        id_ex_valid;
    logic        protocol_err;
`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_count;
`endif

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    if_id_stall_ctrl #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_instr   (imem_instr),
        .pc           (pc),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .id_ex_valid  (id_ex_valid),
`ifdef STALL_COUNTER_EN
        .stall_count  (stall_count),
`endif
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, and settle 1 time unit past the edge.
    task automatic applyStimulus(input logic r, input logic pcw, input logic ifw,
                                 input logic st, input logic br,
                                 input logic [31:0] tgt, input logic [31:0] instr);
        rst           = r;
        PCWrite       = pcw;
        IF_ID_Write   = ifw;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_instr    = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        @(negedge clk);

        // Reset
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_if_id_pc", if_id_pc, 32'h0);
        checkOutput("rst_instr", if_id_instr, 32'h0000_0013);
        checkOutput("rst_if_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rst_ex_valid", {31'b0, id_ex_valid}, 32'h0);
        checkOutput("rst_perr", {31'b0, protocol_err}, 32'h0);
`ifdef STALL_COUNTER_EN
        checkOutput("rst_cnt", {30'b0, stall_count}, 32'h0);
`endif

        // First fetch after reset
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
        checkOutput("f1_pc", pc, 32'h4);
        checkOutput("f1_instr", if_id_instr, 32'h0050_0093);
        checkOutput("f1_if_id_pc", if_id_pc, 32'h0);
        checkOutput("f1_if_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("f1_ex_valid", {31'b0, id_ex_valid}, 32'h0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00a0_0113);
        checkOutput("f2_pc", pc, 32'h8);
        checkOutput("f2_if_id_pc", if_id_pc, 32'h4);
        checkOutput("f2_instr", if_id_instr, 32'h00a0_0113);
        checkOutput("f2_ex_valid", {31'b0, id_ex_valid}, 32'h1);

        // Load-use stall at pc=8
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1111_1111);
        checkOutput("st_pc", pc, 32'h8);
        checkOutput("st_if_id_pc", if_id_pc, 32'h4);
        checkOutput("st_instr", if_id_instr, 32'h00a0_0113);
        checkOutput("st_ex_valid", {31'b0, id_ex_valid}, 32'h0);
        checkOutput("st_perr", {31'b0, protocol_err}, 32'h0);
`ifdef STALL_COUNTER_EN
        checkOutput("st_cnt", {30'b0, stall_count}, 32'h1);
`endif

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
        checkOutput("rel_pc", pc, 32'hC);
        checkOutput("rel_if_id_pc", if_id_pc, 32'h8);
        checkOutput("rel_instr", if_id_instr, 32'h2222_2222);
        checkOutput("rel_ex_valid", {31'b0, id_ex_valid}, 32'h1);

        // Branch concurrent with a consistent stall request
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h3333_3333);
        checkOutput("br_pc", pc, 32'h100);
        checkOutput("br_instr", if_id_instr, 32'h0000_0013);
        checkOutput("br_if_id_pc", if_id_pc, 32'h0);
        checkOutput("br_if_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("br_ex_valid", {31'b0, id_ex_valid}, 32'h0);
        checkOutput("br_perr", {31'b0, protocol_err}, 32'h0);
`ifdef STALL_COUNTER_EN
        checkOutput("br_cnt", {30'b0, stall_count}, 32'h1);
`endif

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
        checkOutput("pbr_pc", pc, 32'h104);
        checkOutput("pbr_if_id_pc", if_id_pc, 32'h100);
        checkOutput("pbr_if_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("pbr_ex_valid", {31'b0, id_ex_valid}, 32'h0);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        checkOutput("wr_br_pc", pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4444_4444);
        checkOutput("wr_pc", pc, 32'h0);
        checkOutput("wr_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        checkOutput("wr_instr", if_id_instr, 32'h4444_4444);
        checkOutput("wr_ex_valid", {31'b0, id_ex_valid}, 32'h0);

        // Inconsistent handshake: PC advances, IF/ID holds, error latches
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_5555);
        checkOutput("pe_perr", {31'b0, protocol_err}, 32'h1);
        checkOutput("pe_pc", pc, 32'h4);
        checkOutput("pe_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
        checkOutput("pe_instr", if_id_instr, 32'h4444_4444);
        checkOutput("pe_ex_valid", {31'b0, id_ex_valid}, 32'h0);
`ifdef STALL_COUNTER_EN
        checkOutput("pe_cnt", {30'b0, stall_count}, 32'h2);
`endif

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h6666_6666);
            checkOutput($sformatf("sticky_perr_%0d", i), {31'b0, protocol_err}, 32'h1);
        end
        checkOutput("sticky_pc", pc, 32'h2C);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst2_perr", {31'b0, protocol_err}, 32'h0);
        checkOutput("rst2_pc", pc, 32'h0);

        // Five consecutive stalls (counter saturates at 3 when enabled)
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h7777_7777);
        end
        checkOutput("ms_pc", pc, 32'h0);
        checkOutput("ms_if_valid", {31'b0, if_id_valid}, 32'h0);
`ifdef STALL_COUNTER_EN
        checkOutput("sat_cnt", {30'b0, stall_count}, 32'h3);
`endif

        // Reset during a stall
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h7777_7777);
        checkOutput("rst3_pc", pc, 32'h0);
        checkOutput("rst3_instr", if_id_instr, 32'h0000_0013);
        checkOutput("rst3_ex_valid", {31'b0, id_ex_valid}, 32'h0);
        checkOutput("rst3_perr", {31'b0, protocol_err}, 32'h0);
`ifdef STALL_COUNTER_EN
        checkOutput("rst3_cnt", {30'b0, stall_count}, 32'h0);
`endif

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
